usb_rx_packet_parser: RTL and testbench



---
 rtl/usb_rx_packet_parser.sv | 190 +++++++++++++++++++
 tb/tb_usb_rx_packet_parser.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: drains the receiver FIFO, checks and classifies the PID,
// extracts token fields and streams DATA payload with the trailing CRC16 stripped.
module usb_rx_packet_parser #(
   parameter int MAX_PAYLOAD = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] rx_r_data,
   input  logic       rx_empty,
   input  logic       rx_rcving,
   input  logic       rx_r_error,
   output logic       rx_r_enable,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       pkt_done,
   output logic [3:0] pkt_pid,
   output logic [6:0] tok_addr,
   output logic [3:0] tok_endp,
   output logic [6:0] pay_len,
   output logic       pid_err,
   output logic       len_err,
   output logic       rx_err
);

   typedef enum logic [2:0] {IDLE, TOK1, TOK2, WEND, HS, DATA, DRAIN, DONE} state_t;

   state_t     state, state_nx;
   logic [7:0] h0, h1;
   logic [1:0] held;

   logic end_cond, pid_ok, stall, hs_accept;
   logic pid_take, tok1_take, tok2_take, shift_in, emit, set_len, set_rx;

   assign end_cond  = !rx_rcving && rx_empty;
   assign pid_ok    = (rx_r_data[7:4] == ~rx_r_data[3:0]) && (rx_r_data[1:0] != 2'b00);
   assign stall     = (held == 2'd2) && data_valid && !data_ready;
   assign hs_accept = data_valid && data_ready;
   assign pkt_done  = (state == DONE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      rx_r_enable = 1'b0;
      pid_take    = 1'b0;
      tok1_take   = 1'b0;
      tok2_take   = 1'b0;
      shift_in    = 1'b0;
      emit        = 1'b0;
      set_len     = 1'b0;
      set_rx      = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_empty) begin
               rx_r_enable = 1'b1;
               pid_take    = 1'b1;
               if (rx_r_error) begin
                  set_rx   = 1'b1;
                  state_nx = DRAIN;
               end else if (!pid_ok) begin
                  state_nx = DRAIN;
               end else begin
                  case (rx_r_data[1:0])
                     2'b01:   state_nx = TOK1;
                     2'b11:   state_nx = DATA;
                     default: state_nx = HS;
                  endcase
               end
            end
         end
         TOK1, TOK2: begin
            if (rx_r_error) begin
               set_rx   = 1'b1;
               state_nx = DRAIN;
            end else if (!rx_empty) begin
               rx_r_enable = 1'b1;
               tok1_take   = (state == TOK1);
               tok2_take   = (state == TOK2);
               state_nx    = (state == TOK1) ? TOK2 : WEND;
            end else if (end_cond) begin
               // Truncated token: report it rather than waiting forever
               set_len  = 1'b1;
               state_nx = DONE;
            end
         end
         WEND, HS: begin
            if (rx_r_error) begin
               set_rx   = 1'b1;
               state_nx = DRAIN;
            end else if (!rx_empty) begin
               set_len  = 1'b1;
               state_nx = DRAIN;
            end else if (end_cond) begin
               state_nx = DONE;
            end
         end
         DATA: begin
            if (rx_r_error) begin
               set_rx   = 1'b1;
               state_nx = DRAIN;
            end else if (!rx_empty && !stall) begin
               rx_r_enable = 1'b1;
               if (held == 2'd2 && pay_len == 7'(MAX_PAYLOAD)) begin
                  set_len  = 1'b1;
                  state_nx = DRAIN;
               end else begin
                  shift_in = 1'b1;
                  emit     = (held == 2'd2);
               end
            end else if (end_cond && !data_valid) begin
               // h0/h1 now hold the CRC16 and are simply dropped
               set_len  = (held != 2'd2);
               state_nx = DONE;
            end
         end
         DRAIN: begin
            set_rx      = rx_r_error;
            rx_r_enable = !rx_empty;
            if (end_cond && !data_valid) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         h0         <= 8'h00;
         h1         <= 8'h00;
         held       <= 2'd0;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         pkt_pid    <= 4'h0;
         tok_addr   <= 7'h00;
         tok_endp   <= 4'h0;
         pay_len    <= 7'd0;
         pid_err    <= 1'b0;
         len_err    <= 1'b0;
         rx_err     <= 1'b0;
      end else begin
         if (pid_take) begin
            pid_err  <= !pid_ok;
            len_err  <= 1'b0;
            rx_err   <= set_rx;
            pay_len  <= 7'd0;
            tok_addr <= 7'h00;
            tok_endp <= 4'h0;
            held     <= 2'd0;
            if (pid_ok) pkt_pid <= rx_r_data[3:0];
         end else begin
            if (set_len) len_err <= 1'b1;
            if (set_rx)  rx_err  <= 1'b1;
         end
         if (tok1_take) begin
            tok_addr    <= rx_r_data[6:0];
            tok_endp[0] <= rx_r_data[7];
         end
         if (tok2_take) tok_endp[3:1] <= rx_r_data[2:0];
         // Two-byte delay line keeps the last two bytes back as the CRC
         if (shift_in) begin
            case (held)
               2'd0: begin
                  h0   <= rx_r_data;
                  held <= 2'd1;
               end
               2'd1: begin
                  h1   <= rx_r_data;
                  held <= 2'd2;
               end
               default: begin
                  h0 <= h1;
                  h1 <= rx_r_data;
               end
            endcase
         end
         if (emit) begin
            data_out   <= h0;
            data_valid <= 1'b1;
            pay_len    <= pay_len + 7'd1;
         end else if (hs_accept) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed bench for usb_rx_packet_parser: a queue models the receiver FIFO and the
// consumer side records every accepted payload byte for comparison.
module tb_usb_rx_packet_parser;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] rx_r_data = 8'h00;
   logic       rx_empty = 1'b1;
   logic       rx_rcving = 1'b0;
   logic       rx_r_error = 1'b0;
   logic       rx_r_enable;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready = 1'b1;
   logic       pkt_done;
   logic [3:0] pkt_pid;
   logic [6:0] tok_addr;
   logic [3:0] tok_endp;
   logic [6:0] pay_len;
   logic       pid_err, len_err, rx_err;

   logic [7:0] fifo[$];
   logic [7:0] got[$];
   logic [7:0] exp_bytes[$];
   int checks = 0;
   int errors = 0;
   int pops, done_cnt, valid_cnt, late_valid, stall_left, err_at;
   bit err_done;
   logic done_dv;

   usb_rx_packet_parser #(.MAX_PAYLOAD(4)) dut (
      .clk(clk), .n_rst(n_rst), .rx_r_data(rx_r_data), .rx_empty(rx_empty),
      .rx_rcving(rx_rcving), .rx_r_error(rx_r_error), .rx_r_enable(rx_r_enable),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .pkt_done(pkt_done), .pkt_pid(pkt_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
      .pay_len(pay_len), .pid_err(pid_err), .len_err(len_err), .rx_err(rx_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [35:0] all_out();
      return {rx_r_enable, data_out, data_valid, pkt_done, pkt_pid, tok_addr,
              tok_endp, pay_len, pid_err, len_err, rx_err};
   endfunction

   task automatic drive_fifo();
      rx_empty  = (fifo.size() == 0);
      rx_r_data = rx_empty ? 8'h00 : fifo[0];
   endtask

   // Sample at the falling edge, then apply FIFO pops and captures just after the rising edge
   task automatic tick();
      logic pop_s, acc_s;
      logic [7:0] byte_s;
      @(negedge clk);
      pop_s  = rx_r_enable;
      acc_s  = data_valid && data_ready;
      byte_s = data_out;
      if (data_valid) valid_cnt++;
      if (err_done && !rx_r_error && data_valid) late_valid++;
      if (pkt_done) begin
         done_cnt++;
         done_dv = data_valid;
      end
      @(posedge clk);
      #1;
      if (pop_s && fifo.size() > 0) begin
         void'(fifo.pop_front());
         pops++;
      end
      if (acc_s) got.push_back(byte_s);
      drive_fifo();
      if (data_valid && stall_left > 0) begin
         data_ready = 1'b0;
         stall_left--;
      end else begin
         data_ready = 1'b1;
      end
      if (err_at > 0 && !err_done && got.size() == err_at) begin
         rx_r_error = 1'b1;
         err_done   = 1'b1;
      end else begin
         rx_r_error = 1'b0;
      end
   endtask

   task automatic applyStimulus(input string name);
      pops = 0; done_cnt = 0; valid_cnt = 0; late_valid = 0; err_done = 0; done_dv = 1'b0;
      got.delete();
      rx_rcving = 1'b1;
      drive_fifo();
      repeat (3) tick();
      rx_rcving = 1'b0;
      for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
      repeat (2) tick();
      checkOutput({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
      checkOutput({name, ".fifo_left"}, 64'(fifo.size()), 64'd0);
   endtask

   task automatic check_payload(input string name);
      checkOutput({name, ".count"}, 64'(got.size()), 64'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size(); i++)
         checkOutput($sformatf("%s.byte%0d", name, i),
                     (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(exp_bytes[i]));
   endtask

   initial begin
      stall_left = 0;
      err_at = 0;
      #2;
      checkOutput("reset_outputs", 64'(all_out()), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      fifo = '{8'hD2};
      applyStimulus("ack");
      checkOutput("ack.pid", 64'(pkt_pid), 64'h2);
      checkOutput("ack.errs", 64'({pid_err, len_err, rx_err}), 64'd0);
      checkOutput("ack.valid_cycles", 64'(valid_cnt), 64'd0);
      checkOutput("ack.pops", 64'(pops), 64'd1);

      fifo = '{8'h69, 8'h85, 8'h01};
      applyStimulus("in_tok");
      checkOutput("in_tok.addr", 64'(tok_addr), 64'h05);
      checkOutput("in_tok.endp", 64'(tok_endp), 64'h3);
      checkOutput("in_tok.pid", 64'(pkt_pid), 64'h9);
      checkOutput("in_tok.errs", 64'({pid_err, len_err, rx_err}), 64'd0);
      checkOutput("in_tok.pops", 64'(pops), 64'd3);

      fifo = '{8'hC3, 8'h01, 8'h40, 8'h61, 8'hAA, 8'hBB};
      exp_bytes = '{8'h01, 8'h40, 8'h61};
      stall_left = 5;
      applyStimulus("data0");
      check_payload("data0");
      checkOutput("data0.pay_len", 64'(pay_len), 64'd3);
      checkOutput("data0.pid", 64'(pkt_pid), 64'h3);
      checkOutput("data0.errs", 64'({pid_err, len_err, rx_err}), 64'd0);
      checkOutput("data0.valid_at_done", 64'(done_dv), 64'd0);

      fifo = '{8'h4B, 8'h12, 8'h34};
      applyStimulus("zlp");
      checkOutput("zlp.valid_cycles", 64'(valid_cnt), 64'd0);
      checkOutput("zlp.pay_len", 64'(pay_len), 64'd0);
      checkOutput("zlp.pid", 64'(pkt_pid), 64'hB);
      checkOutput("zlp.errs", 64'({pid_err, len_err, rx_err}), 64'd0);

      fifo = '{8'h4B, 8'h12};
      applyStimulus("short");
      checkOutput("short.errs", 64'({pid_err, len_err, rx_err}), 64'b010);

      fifo = '{8'hC2, 8'h11, 8'h22};
      applyStimulus("badpid");
      checkOutput("badpid.errs", 64'({pid_err, len_err, rx_err}), 64'b100);
      checkOutput("badpid.pops", 64'(pops), 64'd3);

      fifo = '{8'h69, 8'h85, 8'h01, 8'hAA, 8'hBB, 8'hCC};
      applyStimulus("longtok");
      checkOutput("longtok.errs", 64'({pid_err, len_err, rx_err}), 64'b010);
      checkOutput("longtok.pops", 64'(pops), 64'd6);

      fifo = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE1, 8'hE2};
      exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus("maxlen");
      check_payload("maxlen");
      checkOutput("maxlen.pay_len", 64'(pay_len), 64'd4);
      checkOutput("maxlen.errs", 64'({pid_err, len_err, rx_err}), 64'd0);

      fifo = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hE1, 8'hE2};
      applyStimulus("overlen");
      check_payload("overlen");
      checkOutput("overlen.pay_len", 64'(pay_len), 64'd4);
      checkOutput("overlen.errs", 64'({pid_err, len_err, rx_err}), 64'b010);

      fifo = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      exp_bytes = '{8'h11, 8'h22, 8'h33};
      err_at = 2;
      applyStimulus("rxerr");
      err_at = 0;
      check_payload("rxerr");
      checkOutput("rxerr.errs", 64'({pid_err, len_err, rx_err}), 64'b001);
      checkOutput("rxerr.late_valid", 64'(late_valid), 64'd0);
      checkOutput("rxerr.pops", 64'(pops), 64'd8);

      fifo = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB};
      rx_rcving = 1'b1;
      drive_fifo();
      repeat (5) tick();
      n_rst = 1'b0;
      fifo.delete();
      drive_fifo();
      rx_rcving = 1'b0;
      #1;
      checkOutput("midreset.outputs", 64'(all_out()), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      fifo = '{8'hE1, 8'h9A, 8'h05};
      applyStimulus("out_tok");
      checkOutput("out_tok.addr", 64'(tok_addr), 64'h1A);
      checkOutput("out_tok.endp", 64'(tok_endp), 64'hB);
      checkOutput("out_tok.pid", 64'(pkt_pid), 64'h1);
      checkOutput("out_tok.errs", 64'({pid_err, len_err, rx_err}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
